spi_packet_rx: RTL and testbench

SPI_PACKET_RX -- requirements
Module: spi_packet_rx

---
 rtl/spi_rx_pkg.sv | 17 +
 rtl/spi_sync.sv | 25 ++
 rtl/spi_packet_rx.sv | 169 ++++++++++++++++
 tb/tb_spi_packet_rx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI packet receiver.
//   DEF_* : default widths and shift order for spi_packet_rx
//   state_t : receiver FSM states
package spi_rx_pkg;

  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_NUM_REGS  = 4;
  localparam int unsigned DEF_LSB_FIRST = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output
module spi_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_packet_rx.sv
// SPI slave receiver: collects one {addr, data} packet per cs frame and
// writes the data field into a small register bank.
//   clk, reset : system clock, synchronous active-high reset
//   cs, sck, sdi : asynchronous SPI frame select, serial clock, serial data
//   regs       : register bank, channel k at [k*DATA_W +: DATA_W]
//   pkt_valid  : pulse when a full-length packet commits
//   pkt_addr   : address of last committed packet
//   pkt_data   : data of last committed packet
//   frame_err  : pulse when a frame ends with the wrong bit count
//   addr_err   : pulse with pkt_valid when the address has no register
//   busy       : receiver is inside a frame
module spi_packet_rx
  import spi_rx_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
  parameter int unsigned LSB_FIRST = DEF_LSB_FIRST
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cs,
  input  logic                       sck,
  input  logic                       sdi,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       pkt_valid,
  output logic [ADDR_W-1:0]          pkt_addr,
  output logic [DATA_W-1:0]          pkt_data,
  output logic                       frame_err,
  output logic                       addr_err,
  output logic                       busy
);

  localparam int unsigned P  = ADDR_W + DATA_W;
  localparam int unsigned CW = $clog2(P + 2);

  state_t state, state_n;

  logic cs_s, sck_s, sdi_s;
  logic cs_d, sck_d;
  logic [1:0] prime;
  logic armed;

  logic [P-1:0]  sr;
  logic [P-1:0]  sr_shifted;
  logic [CW-1:0] cnt;

  logic cs_rise_c, cs_fall_c, sck_rise_c;
  logic do_clear, do_shift, do_commit;
  logic [ADDR_W-1:0] sr_addr;
  logic [DATA_W-1:0] sr_data;
  logic addr_ok;

  spi_sync u_sync_cs  (.clk(clk), .reset(reset), .d(cs),  .q(cs_s));
  spi_sync u_sync_sck (.clk(clk), .reset(reset), .d(sck), .q(sck_s));
  spi_sync u_sync_sdi (.clk(clk), .reset(reset), .d(sdi), .q(sdi_s));

  // Third copy for edge detection. prime marks when the synchronizer outputs
  // reflect the pins again after reset; armed requires cs to be seen low
  // first, so a cs held high through reset cannot fake a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_d  <= 1'b0;
      sck_d <= 1'b0;
      prime <= 2'b00;
      armed <= 1'b0;
    end else begin
      cs_d  <= cs_s;
      sck_d <= sck_s;
      prime <= {prime[0], 1'b1};
      if (prime[1] && !cs_s) armed <= 1'b1;
    end
  end

  assign cs_rise_c  = cs_s & ~cs_d & armed;
  assign cs_fall_c  = ~cs_s & cs_d;
  assign sck_rise_c = sck_s & ~sck_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and datapath strobes; cs fall wins over a coincident sck rise
  always_comb begin
    state_n   = state;
    do_clear  = 1'b0;
    do_shift  = 1'b0;
    do_commit = 1'b0;
    case (state)
      IDLE: begin
        if (cs_rise_c) begin
          state_n  = SHIFT;
          do_clear = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_fall_c)       state_n  = COMMIT;
        else if (sck_rise_c) do_shift = 1'b1;
      end
      COMMIT: begin
        state_n   = IDLE;
        do_commit = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift direction: MSB-first enters at bit 0, LSB-first enters at the top
  always_comb begin
    sr_shifted = sr;
    if (LSB_FIRST != 0) sr_shifted = {sdi_s, sr[P-1:1]};
    else                sr_shifted = {sr[P-2:0], sdi_s};
  end

  assign sr_addr = sr[P-1 -: ADDR_W];
  assign sr_data = sr[DATA_W-1:0];
  assign addr_ok = (32'(sr_addr) < NUM_REGS);

  // Shift register and saturating bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (do_clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (do_shift) begin
      sr <= sr_shifted;
      if (cnt != CW'(P + 1)) cnt <= cnt + CW'(1);
    end
  end

  // Registered outputs and register bank update on commit
  always_ff @(posedge clk) begin
    if (reset) begin
      regs      <= '0;
      pkt_valid <= 1'b0;
      pkt_addr  <= '0;
      pkt_data  <= '0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      busy      <= (state_n != IDLE);
      if (do_commit) begin
        if (cnt == CW'(P)) begin
          pkt_valid <= 1'b1;
          pkt_addr  <= sr_addr;
          pkt_data  <= sr_data;
          if (addr_ok) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
              if (32'(sr_addr) == k) regs[k*DATA_W +: DATA_W] <= sr_data;
            end
          end else begin
            addr_err <= 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_packet_rx.sv
// Bench for spi_packet_rx: an MSB-first and an LSB-first instance share the
// same serial lines and are each checked against a packet-level model.
module tb_spi_packet_rx;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NR = 4;
  localparam int P  = AW + DW;

  logic clk = 1'b0;
  logic reset, cs, sck, sdi;

  logic [NR*DW-1:0] regs_m, regs_l;
  logic             pkt_valid_m, pkt_valid_l;
  logic [AW-1:0]    pkt_addr_m, pkt_addr_l;
  logic [DW-1:0]    pkt_data_m, pkt_data_l;
  logic             frame_err_m, frame_err_l;
  logic             addr_err_m, addr_err_l;
  logic             busy_m, busy_l;

  spi_packet_rx #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .LSB_FIRST(0)) dut_m (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck), .sdi(sdi),
    .regs(regs_m), .pkt_valid(pkt_valid_m), .pkt_addr(pkt_addr_m),
    .pkt_data(pkt_data_m), .frame_err(frame_err_m), .addr_err(addr_err_m),
    .busy(busy_m)
  );

  spi_packet_rx #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .LSB_FIRST(1)) dut_l (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck), .sdi(sdi),
    .regs(regs_l), .pkt_valid(pkt_valid_l), .pkt_addr(pkt_addr_l),
    .pkt_data(pkt_data_l), .frame_err(frame_err_l), .addr_err(addr_err_l),
    .busy(busy_l)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model state, index 0 = MSB-first instance, 1 = LSB-first instance
  logic [DW-1:0] mr [2][NR];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] md [2];
  logic [2:0]    ep [2];   // {pkt_valid, frame_err, addr_err} expected on commit

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] msb_seq(input logic [P-1:0] p);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < P; i++) s[i] = p[P-1-i];
    return s;
  endfunction

  function automatic logic [NR*DW-1:0] flat(input int j);
    logic [NR*DW-1:0] f;
    for (int k = 0; k < NR; k++) f[k*DW +: DW] = mr[j][k];
    return f;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < NR; k++) mr[j][k] = '0;
      ma[j] = '0;
      md[j] = '0;
      ep[j] = 3'b000;
    end
  endtask

  // seq[i] is the i-th bit on the wire; only a frame of exactly P bits commits
  task automatic model_frame(input logic [63:0] seq, input int n);
    logic [P-1:0] p;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int j = 0; j < 2; j++) begin
      if (n != P) begin
        ep[j] = 3'b010;
      end else begin
        for (int i = 0; i < P; i++) begin
          if (j == 0) p[P-1-i] = seq[i];
          else        p[i]     = seq[i];
        end
        a = p[P-1 -: AW];
        d = p[DW-1:0];
        ma[j] = a;
        md[j] = d;
        if (int'(a) < NR) begin
          mr[j][int'(a)] = d;
          ep[j] = 3'b100;
        end else begin
          ep[j] = 3'b101;
        end
      end
    end
  endtask

  task automatic shift_bits(input logic [63:0] seq, input int n);
    cs = 1'b1;
    cyc(4);
    for (int i = 0; i < n; i++) begin
      sdi = seq[i];
      cyc(3);
      sck = 1'b1;
      cyc(3);
      sck = 1'b0;
    end
    cyc(3);
  endtask

  // Full frame: shift, drop cs, check pulse timing (3 cycles after cs low is
  // sampled), then check held outputs of both instances.
  task automatic run_frame(input string tag, input logic [63:0] seq, input int n);
    logic [2:0] got, exp;
    shift_bits(seq, n);
    vectors++;
    if ({busy_m, busy_l} !== 2'b11) begin
      errors++;
      $display("FAIL %s busy_in_frame: got %b expected 11", tag, {busy_m, busy_l});
    end
    model_frame(seq, n);
    cs  = 1'b0;
    sdi = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      got = {pkt_valid_m, frame_err_m, addr_err_m};
      exp = (k == 3) ? ep[0] : 3'b000;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s pulses_msb cyc%0d: got %b expected %b", tag, k, got, exp);
      end
      got = {pkt_valid_l, frame_err_l, addr_err_l};
      exp = (k == 3) ? ep[1] : 3'b000;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s pulses_lsb cyc%0d: got %b expected %b", tag, k, got, exp);
      end
    end
    vectors++;
    if (regs_m !== flat(0)) begin
      errors++;
      $display("FAIL %s regs_msb: got %h expected %h", tag, regs_m, flat(0));
    end
    vectors++;
    if (regs_l !== flat(1)) begin
      errors++;
      $display("FAIL %s regs_lsb: got %h expected %h", tag, regs_l, flat(1));
    end
    vectors++;
    if ({pkt_addr_m, pkt_data_m} !== {ma[0], md[0]}) begin
      errors++;
      $display("FAIL %s pkt_msb: got %h expected %h", tag, {pkt_addr_m, pkt_data_m}, {ma[0], md[0]});
    end
    vectors++;
    if ({pkt_addr_l, pkt_data_l} !== {ma[1], md[1]}) begin
      errors++;
      $display("FAIL %s pkt_lsb: got %h expected %h", tag, {pkt_addr_l, pkt_data_l}, {ma[1], md[1]});
    end
    vectors++;
    if ({busy_m, busy_l} !== 2'b00) begin
      errors++;
      $display("FAIL %s busy_after: got %b expected 00", tag, {busy_m, busy_l});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 1'b0; sck = 1'b0; sdi = 1'b0;
    cyc(3);
    reset = 1'b0;
    model_reset();
    vectors++;
    if ({regs_m, regs_l} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0", {regs_m, regs_l});
    end
    vectors++;
    if ({pkt_valid_m, frame_err_m, addr_err_m, busy_m, pkt_addr_m, pkt_data_m,
         pkt_valid_l, frame_err_l, addr_err_l, busy_l, pkt_addr_l, pkt_data_l} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero expected 0");
    end
    cyc(4);
  endtask

  task automatic test_basic();
    run_frame("basic_0114ff", msb_seq(24'h0114FF), P);
    vectors++;
    if (regs_m[1*DW +: DW] !== 16'h14FF) begin
      errors++;
      $display("FAIL basic_ch1: got %h expected 14ff", regs_m[1*DW +: DW]);
    end
  endtask

  task automatic test_bad_length();
    run_frame("short_23", msb_seq(24'h02AAAA), P - 1);
    run_frame("long_25", msb_seq(24'h035555) | 64'h1_000000, P + 1);
    run_frame("long_56_saturate", 64'h00FF_FFFF_FFFF_FFFF, 56);
  endtask

  task automatic test_addr_err();
    run_frame("addr_07abcd", msb_seq(24'h07ABCD), P);
  endtask

  task automatic test_lsb_first();
    run_frame("lsb_03beef", 64'h03BEEF, P);
    vectors++;
    if (regs_l[3*DW +: DW] !== 16'hBEEF) begin
      errors++;
      $display("FAIL lsb_ch3: got %h expected beef", regs_l[3*DW +: DW]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] got;
    cs = 1'b1;
    cyc(4);
    for (int i = 0; i < 10; i++) begin
      sdi = 1'($urandom);
      cyc(3);
      sck = 1'b1;
      cyc(3);
      sck = 1'b0;
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    model_reset();
    vectors++;
    if ({regs_m, regs_l, pkt_addr_m, pkt_data_m, pkt_addr_l, pkt_data_l} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got nonzero expected 0");
    end
    cyc(6);
    vectors++;
    if ({busy_m, busy_l} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_no_restart: got busy %b expected 00", {busy_m, busy_l});
    end
    cs = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      got = {pkt_valid_m | pkt_valid_l, frame_err_m | frame_err_l, addr_err_m | addr_err_l};
      vectors++;
      if (got !== 3'b000) begin
        errors++;
        $display("FAIL midreset_cs_fall cyc%0d: got %b expected 000", k, got);
      end
    end
    run_frame("post_reset_021234", msb_seq(24'h021234), P);
    vectors++;
    if (regs_m[2*DW +: DW] !== 16'h1234) begin
      errors++;
      $display("FAIL post_reset_ch2: got %h expected 1234", regs_m[2*DW +: DW]);
    end
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_000001", msb_seq(24'h000001), P);
    run_frame("b2b_000002", msb_seq(24'h000002), P);
    vectors++;
    if (regs_m[0 +: DW] !== 16'h0002) begin
      errors++;
      $display("FAIL b2b_ch0: got %h expected 0002", regs_m[0 +: DW]);
    end
  endtask

  task automatic test_random();
    int n;
    logic [P-1:0] p;
    logic [63:0] seq;
    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 5))
        0:       n = P - 1;
        1:       n = P + 1;
        2:       n = P + 2;
        default: n = P;
      endcase
      p   = {AW'($urandom_range(0, 5)), DW'($urandom)};
      seq = msb_seq(p);
      seq[63:P] = (64 - P)'({$urandom, $urandom});
      run_frame($sformatf("random_%0d", t), seq, n);
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; sck = 1'b0; sdi = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_bad_length();
    test_addr_err();
    test_lsb_first();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
